onchip_ram_avmm: RTL and testbench
==================================

# onchip_ram_avmm

Parametrised on-chip RAM with an Avalon-MM slave, the next generation of the Nios II system's single-port on-chip memory. It adds generic width and depth, selectable read latency with explicit `avs_readdatavalid` pipelining, and `avs_waitrequest` back-pressure. A post-reset zero-clear sequencer guarantees deterministic contents before the CPU fetches. It sits on the system interconnect as an instruction/data memory slave.

## Interface

Parameters:
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 13: word-address width.
- `DEPTH`, 5120: number of words; must satisfy `DEPTH <= 2**ADDR_W`.
- `READ_LATENCY`, 1: read latency in cycles; legal values are 1 and 2 only.
- `INIT_CLEAR`, 1: when 1, memory is zero-filled after every reset.

Ports:
- `clk` input 1: the single clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `avs_address` input `ADDR_W`: word address.
- `avs_byteenable` input `DATA_W/8`: write byte lanes.
- `avs_chipselect` input 1: slave select.
- `avs_read` input 1: read request.
- `avs_write` input 1: write request.
- `avs_writedata` input `DATA_W`: write data.
- `avs_readdata` output `DATA_W`: read data; meaningful only when `avs_readdatavalid` is 1.
- `avs_readdatavalid` output 1: read data valid.
- `avs_waitrequest` output 1: slave busy; the current request is not accepted.
- `clken` input 1: clock enable; 0 freezes the block.
- `reset_req` input 1: reset-in-progress hint; treated exactly as `clken=0`.
- `init_done` output 1: goes to 1 once the zero-clear completes.

## Operation

- States: CLEAR and READY. On reset, enter CLEAR if `INIT_CLEAR=1`, otherwise READY.
- CLEAR:
  - A clear counter runs 0 to DEPTH-1, writing all-zeros with all byte lanes enabled, one word per enabled cycle.
  - After the write to DEPTH-1, move to READY.
  - Bus requests are never accepted in CLEAR.
- `stall = ~clken | reset_req`. While `stall` is 1:
  - the RAM, the clear counter and the read pipeline all hold;
  - `avs_readdatavalid` is 0.
  - A valid pending in the pipeline is delivered after `stall` drops.
- `avs_waitrequest = (state==CLEAR) | stall`. This is combinational from state and inputs, and is 1 during reset.
- Accept: `avs_chipselect & ~avs_waitrequest & (avs_read | avs_write)`.
- Write: each byte lane `i` with `avs_byteenable[i]=1` is updated; other lanes keep their value.
- If read and write are both asserted in the same cycle, the write wins. The read is dropped and produces no `avs_readdatavalid`.
- Out-of-range address (`avs_address >= DEPTH`):
  - the write is discarded;
  - the read is accepted and returns 0 with a normal `avs_readdatavalid`.
- Read-during-write to the same word in consecutive cycles: the read returns the newly written data. The RAM is configured new-data or the block adds a bypass.
- Reset asserted mid-CLEAR or mid-read:
  - pending valids are discarded;
  - the clear restarts from address 0 on release.
  - RAM contents are not reset directly.

## Timing

Reset values of all outputs:
- `avs_readdata` = 0
- `avs_readdatavalid` = 0
- `init_done` = 0
- `avs_waitrequest` = 1

Reads:
- A read accepted at the edge ending cycle N returns `avs_readdatavalid=1` in cycle N+`READ_LATENCY`, assuming no stall cycles.
- Each stall cycle adds one cycle of delay.
- Throughput is one read or write per cycle, with back-to-back reads in order.
- `avs_readdata` holds its last value when `avs_readdatavalid` is 0.

Clear:
- The first clear write occurs on the first enabled edge after `reset_n` rises.
- `init_done` and `avs_waitrequest=0` appear DEPTH enabled cycles after that edge.
- With `INIT_CLEAR=0`, `init_done` is 1 and requests are accepted from the first cycle after reset release.

## Structure

Shared package `onchip_ram_pkg` contains:
- the state enum {CLEAR, READY};
- the legal `READ_LATENCY` range constants;
- a `clog2`-based function for the width of the clear counter.

One natural sub-module, `onchip_ram_core`:
- an inferred simple-dual-port byte-enabled RAM array (write port shared by bus and clear, read port from the bus);
- synchronous read with an optional output register selected by `READ_LATENCY`.

The top level holds the clear FSM, the valid pipeline, the range check and the waitrequest logic.

## Test plan

- Reset, `INIT_CLEAR=1`, `DEPTH=16` → `avs_waitrequest=1` for exactly 16 cycles. `init_done` rises on cycle 16. Reads of all addresses return 0.
- Write `0xDEADBEEF` to addr 3 with byteenable `0b0101`, then read addr 3 → `0x00AD00EF`, valid exactly `READ_LATENCY` cycles after accept, for both `READ_LATENCY=1` and 2.
- Back-to-back reads of addrs 0..7 (preloaded with value=addr) with `clken` low for 2 cycles mid-burst → 8 valids in order, data 0..7. Stall cycles add no duplicate or lost valids.
- Write then read address `DEPTH` (out of range) → write ignored, readdata 0 with valid. Word 0 is unchanged (no aliasing).
- Simultaneous read+write to addr 5 → write lands. No readdatavalid is produced for that request.
- Assert `reset_n=0` at clear count 7, release → clear restarts at 0. `init_done` comes DEPTH cycles after release. An in-flight read valid is dropped.

Source files
------------

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the on-chip RAM Avalon-MM slave.
package onchip_ram_pkg;

    // Controller state: CLEAR while zero-filling the array, READY for bus traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Supported read latencies (cycles from accept to readdatavalid).
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // Width of a counter/index that spans 0..depth-1 (at least one bit).
    function automatic int clear_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled simple-dual-port RAM with synchronous read and an optional
// second output register. One write port (bus or clear), one read port (bus).
module onchip_ram_core
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter int IDX_W        = clear_cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic                  rzero,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1;

    // Byte-lane write; lanes with a clear enable bit keep their old value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // First read stage; out-of-range reads load zero instead of the array.
    // A write to the same word on the previous edge is already in the array,
    // so back-to-back write-then-read returns the new data without a bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rd1 <= '0;
        else if (en && re) rd1 <= rzero ? '0 : mem[raddr];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] rd2;

        // Output register, advancing only on enabled cycles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) rd2 <= '0;
            else if (en)  rd2 <= rd1;
        end

        assign rdata = rd2;
    end else begin : g_lat1
        assign rdata = rd1;
    end

endmodule

// File: rtl/onchip_ram_avmm.sv
// On-chip RAM with an Avalon-MM slave port and post-reset zero clear.
//
// Handshake: a request (chipselect & (read|write)) is accepted on a clock edge
// where avs_waitrequest is 0; while waitrequest is 1 the master must hold it.
// Each accepted read (not paired with a write) yields exactly one
// avs_readdatavalid pulse, in order, READ_LATENCY enabled cycles later; there
// is no back-pressure on the read-data return path.
module onchip_ram_avmm
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic                  avs_chipselect,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic                  avs_waitrequest,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic                  init_done
);

    localparam int IDX_W = clear_cnt_w(DEPTH);
    // Anything other than the two legal latencies is clamped to the nearest one.
    localparam int RL    = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX
                                                               : READ_LATENCY_MIN;

    ram_state_t        state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [RL-1:0]     vld;

    logic stall;
    logic in_range;
    logic bus_acc;
    logic wr_acc;
    logic rd_acc;
    logic clr_we;
    logic clearing;

    assign stall    = ~clken | reset_req;
    assign clearing = (state == CLEAR);

    // Busy while in reset, while clearing, or while frozen.
    assign avs_waitrequest = ~reset_n | clearing | stall;

    assign in_range = {1'b0, avs_address} < (ADDR_W+1)'(DEPTH);
    assign bus_acc  = avs_chipselect & ~avs_waitrequest & (avs_read | avs_write);
    assign wr_acc   = bus_acc & avs_write;
    assign rd_acc   = bus_acc & avs_read & ~avs_write;   // write wins; read dropped
    assign clr_we   = reset_n & clearing & ~stall;

    assign init_done = reset_n & (state == READY);

    // Clear sequencer: one zero word per enabled cycle, then hand over to the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (INIT_CLEAR != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (!stall && state == CLEAR) begin
            if (clr_cnt == IDX_W'(DEPTH - 1)) state   <= READY;
            else                             clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Read-valid pipeline; frozen by stall so pending valids are not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
        end else if (!stall) begin
            vld[0] <= rd_acc;
            for (int i = 1; i < RL; i++) vld[i] <= vld[i-1];
        end
    end

    assign avs_readdatavalid = vld[RL-1] & ~stall;

    onchip_ram_core #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .IDX_W        (IDX_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~stall),
        .we      (clr_we | (wr_acc & in_range)),
        .waddr   (clearing ? clr_cnt : avs_address[IDX_W-1:0]),
        .wbe     (clearing ? '1 : avs_byteenable),
        .wdata   (clearing ? '0 : avs_writedata),
        .re      (rd_acc),
        .rzero   (~in_range),
        .raddr   (avs_address[IDX_W-1:0]),
        .rdata   (avs_readdata)
    );

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Bench for onchip_ram_avmm: two instances (read latency 1 and 2) share one
// stimulus stream; each has its own expected-read queue checked by a monitor.
module tb_onchip_ram_avmm;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int NB     = DATA_W / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic [ADDR_W-1:0]   avs_address;
    logic [NB-1:0]       avs_byteenable;
    logic                avs_chipselect;
    logic                avs_read;
    logic                avs_write;
    logic [DATA_W-1:0]   avs_writedata;
    logic                clken;
    logic                reset_req;

    logic [DATA_W-1:0]   rdata1, rdata2;
    logic                rvalid1, rvalid2;
    logic                wait1, wait2;
    logic                done1, done2;

    onchip_ram_avmm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_CLEAR(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
        .avs_byteenable(avs_byteenable), .avs_chipselect(avs_chipselect),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata1), .avs_readdatavalid(rvalid1), .avs_waitrequest(wait1),
        .clken(clken), .reset_req(reset_req), .init_done(done1)
    );

    onchip_ram_avmm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_CLEAR(1)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
        .avs_byteenable(avs_byteenable), .avs_chipselect(avs_chipselect),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata2), .avs_readdatavalid(rvalid2), .avs_waitrequest(wait2),
        .clken(clken), .reset_req(reset_req), .init_done(done2)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;   // enabled (unstalled) clock edges seen so far

    logic [DATA_W-1:0] exp_q1[$];
    logic [DATA_W-1:0] exp_q2[$];
    int                due_q1[$];
    int                due_q2[$];

    always @(posedge clk) begin
        if (clken && !reset_req) ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        logic [DATA_W-1:0] e;
        int                d;
        if (rvalid1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL lat1_unexpected_valid: got readdata 0x%08h, expected no valid", rdata1);
            end else begin
                e = exp_q1.pop_front();
                d = due_q1.pop_front();
                chk("lat1_readdata", rdata1, e);
                chk("lat1_latency", 32'(ecnt), 32'(d));
            end
        end
        if (rvalid2 === 1'b1) begin
            if (exp_q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL lat2_unexpected_valid: got readdata 0x%08h, expected no valid", rdata2);
            end else begin
                e = exp_q2.pop_front();
                d = due_q2.pop_front();
                chk("lat2_readdata", rdata2, e);
                chk("lat2_latency", 32'(ecnt), 32'(d));
            end
        end
    end

    // ---------------- driver tasks (entered/left just after a rising edge) ----------------
    task automatic wait_accept(input string name);
        int tries = 0;
        @(negedge clk);
        while (wait1 && tries < 64) begin
            tries++;
            @(negedge clk);
        end
        if (wait1) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got waitrequest 1 after %0d cycles, expected 0", name, tries);
        end
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [NB-1:0] be,
                             input logic [DATA_W-1:0] d);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
        avs_address = a; avs_byteenable = be; avs_writedata = d;
        wait_accept("write");
        @(posedge clk); #1;
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = a;
        wait_accept("read");
        exp_q1.push_back(exp); due_q1.push_back(ecnt + 1);
        exp_q2.push_back(exp); due_q2.push_back(ecnt + 2);
        @(posedge clk); #1;
        avs_chipselect = 1'b0; avs_read = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata1"}, rdata1, 32'h0);
        chk({tag, "_rdata2"}, rdata2, 32'h0);
        chk_bit({tag, "_valid1"}, rvalid1, 1'b0);
        chk_bit({tag, "_valid2"}, rvalid2, 1'b0);
        chk_bit({tag, "_wait1"}, wait1, 1'b1);
        chk_bit({tag, "_wait2"}, wait2, 1'b1);
        chk_bit({tag, "_done1"}, done1, 1'b0);
        chk_bit({tag, "_done2"}, done2, 1'b0);
    endtask

    // Called just after reset release: counts busy cycles of the clear.
    task automatic count_clear(input string tag);
        int n = 0;
        bit early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!wait1) break;
            if (done1 || done2) early = 1'b1;
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(DEPTH));
        chk_bit({tag, "_done_early"}, early, 1'b0);
        chk_bit({tag, "_done1"}, done1, 1'b1);
        chk_bit({tag, "_done2"}, done2, 1'b1);
        chk_bit({tag, "_wait2"}, wait2, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        avs_address = '0; avs_byteenable = '0; avs_writedata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        @(posedge clk); #1 reset_n = 1'b1;
        count_clear("init");

        // Whole array reads back zero after the clear.
        for (int a = 0; a < DEPTH; a++) bus_read(ADDR_W'(a), 32'h0);

        // Byte lanes 0 and 2 only.
        bus_write(5'd3, 4'b0101, 32'hDEAD_BEEF);
        bus_read(5'd3, 32'h00AD_00EF);

        // Preload value = address, then a read burst frozen for two cycles.
        for (int a = 0; a < 8; a++) bus_write(ADDR_W'(a), 4'hF, 32'(a));
        for (int a = 0; a < 4; a++) bus_read(ADDR_W'(a), 32'(a));
        clken = 1'b0;
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 5'd4;
        repeat (2) @(posedge clk);
        #1 clken = 1'b1;
        for (int a = 4; a < 8; a++) bus_read(ADDR_W'(a), 32'(a));

        // reset_req behaves like a one-cycle freeze.
        bus_read(5'd1, 32'd1);
        reset_req = 1'b1;
        @(posedge clk); #1 reset_req = 1'b0;
        bus_read(5'd2, 32'd2);

        // Out-of-range write is discarded and does not alias onto word 0.
        bus_write(5'd16, 4'hF, 32'h1234_5678);
        bus_read(5'd16, 32'h0);
        bus_read(5'd0, 32'h0);

        // Read and write together: write lands, no read response.
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
        avs_address = 5'd5; avs_byteenable = 4'hF; avs_writedata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        bus_read(5'd5, 32'hA5A5_5A5A);

        // Read immediately after a write to the same word sees the new data.
        bus_write(5'd9, 4'hF, 32'hCAFE_F00D);
        bus_read(5'd9, 32'hCAFE_F00D);
        bus_write(5'd9, 4'b1000, 32'h11FF_FFFF);
        bus_read(5'd9, 32'h11FE_F00D);

        repeat (4) @(posedge clk);
        #1;

        // In-flight read dropped by reset.
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 5'd9;
        @(posedge clk); #1;
        reset_n = 1'b0; avs_chipselect = 1'b0; avs_read = 1'b0;
        @(negedge clk);
        check_reset_outputs("inflight_reset");

        // Reset again at clear count 7; the clear must restart from 0.
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk_bit("midclear_reset_wait1", wait1, 1'b1);
        chk_bit("midclear_reset_done1", done1, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        count_clear("restart");

        bus_read(5'd3, 32'h0);
        bus_read(5'd5, 32'h0);
        bus_read(5'd9, 32'h0);
        bus_read(5'd15, 32'h0);
        bus_write(5'd15, 4'b0011, 32'hFFFF_1234);
        bus_read(5'd15, 32'h0000_1234);

        repeat (6) @(posedge clk);
        #1;
        chk("lat1_queue_left", 32'(exp_q1.size()), 32'h0);
        chk("lat2_queue_left", 32'(exp_q2.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
